vscale_imm_enc: RTL and testbench
=================================

VSCALE_IMM_ENC -- requirements
Module: vscale_imm_enc

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the saturating error counter.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: request present.
REQ-005 SHALL have port in_ready, output, 1 bit: request accepted when in_valid and in_ready are both high.
REQ-006 SHALL have port in_inst, input, 32 bits: base instruction; bits not covered by the immediate pass through unchanged.
REQ-007 SHALL have port in_imm, input, 32 bits: immediate value to encode.
REQ-008 SHALL have port in_imm_type, input, 3 bits: 0=IMM_I, 1=IMM_S, 2=IMM_U, 3=IMM_J; codes 4-7 are treated as IMM_I.
REQ-009 SHALL have port out_valid, output, 1 bit: result present.
REQ-010 SHALL have port out_ready, input, 1 bit: result consumed when out_valid and out_ready are both high.
REQ-011 SHALL have port out_inst, output, 32 bits: instruction with the immediate fields inserted.
REQ-012 SHALL have port out_range_err, output, 1 bit: the immediate is not exactly representable in the selected format.
REQ-013 SHALL have port err_count, output, CNT_WIDTH bits: saturating count of range errors delivered at the output.

Function
REQ-014 SHALL insert the IMM_I immediate as inst[31:20]=imm[11:0]; the value is representable iff imm[31:11] are all equal.
REQ-015 SHALL insert the IMM_S immediate as inst[31:25]=imm[11:5] and inst[11:7]=imm[4:0]; representability is the same as for IMM_I.
REQ-016 SHALL insert the IMM_U immediate as inst[31:12]=imm[31:12]; the value is representable iff imm[11:0]==0.
REQ-017 SHALL insert the IMM_J immediate as inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]; the value is representable iff imm[31:20] are all equal and imm[0]==0.
REQ-018 SHALL always insert the truncated fields, even when the value is out of range.
REQ-019 SHALL be a two-stage pipeline: stage 1 registers the accepted request, and stage 2 holds the encoded result and error flag.
REQ-020 SHALL deliver a result with latency 2, i.e. out_valid is high on the second rising edge after acceptance when there is no backpressure.
REQ-021 SHALL sustain one transaction per cycle when out_ready is held high.
REQ-022 SHALL drive in_ready = !stage1_valid | !stage2_valid | out_ready, so that no transaction is dropped or duplicated under backpressure.
REQ-023 SHALL advance stage 1 into stage 2 when stage 2 is empty or is being consumed in the same cycle.
REQ-024 SHALL hold out_inst and out_range_err stable while out_valid is high and out_ready is low.
REQ-025 SHALL, on a simultaneous accept at the input and consume at the output with both stages full, advance both stages in the same cycle with no bubble.
REQ-026 SHALL increment err_count by 1 on each output handshake where out_range_err is high, and SHALL hold it at all-ones once saturated.

Reset
REQ-027 SHALL, when reset_n is low at a clock edge, clear both stage valid bits, out_inst, out_range_err and err_count to 0.
REQ-028 SHALL discard in-flight transactions when reset is asserted mid-operation; none of them appears after reset is released.
REQ-029 SHALL hold in_ready low while reset_n is low, and SHALL drive it high on the first cycle after reset_n is high at an edge.

Configuration
REQ-030 SHALL, with VSCALE_IMM_ENC_RANGE_CHECK_EN defined, implement the range check of REQ-014 to REQ-017 and the counter of REQ-026.
REQ-031 SHALL, without VSCALE_IMM_ENC_RANGE_CHECK_EN defined, tie out_range_err and err_count to constant 0 and synthesize no check or counter logic, with field insertion unchanged.

Verification
REQ-032 SHALL cover: IMM_I, in_inst=0x00000013, in_imm=0xFFFFFFFF, out_ready=1 -> two cycles later out_inst=0xFFF00013, out_range_err=0.
REQ-033 SHALL cover: IMM_J, in_inst=0x0000006F, in_imm=0x00000800 -> out_inst=0x0010006F, out_range_err=0; then in_imm=0x00000801 -> out_range_err=1 and err_count=1.
REQ-034 SHALL cover: IMM_U, in_imm=0x12345000 -> out_inst[31:12]=0x12345, out_range_err=0; then in_imm=0x12345001 -> out_range_err=1.
REQ-035 SHALL cover: 8 back-to-back requests with out_ready low for cycles 3-6 -> in_ready falls low once both stages are full, and all 8 results appear in order with no loss or duplication.
REQ-036 SHALL cover: with CNT_WIDTH=2, 5 out-of-range requests -> err_count steps 1, 2, 3, then stays at 3.
REQ-037 SHALL cover: reset_n pulsed low with 2 transactions in flight -> out_valid=0 and err_count=0, and no stale result appears afterwards.

Source files
------------

// File: rtl/vscale_imm_enc.sv
// Two-stage RISC-V immediate encoder with valid/ready handshakes on both sides.
// Optional range check and saturating error counter: VSCALE_IMM_ENC_RANGE_CHECK_EN.
module vscale_imm_enc #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [31:0]          in_imm,
  input  logic [2:0]           in_imm_type,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_range_err,
  output logic [CNT_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_U = 2'd2,
    IMM_J = 2'd3
  } imm_t;

  logic        r_rdy;
  logic        r_s1_valid;
  logic [31:0] r_s1_inst;
  logic [31:0] r_s1_imm;
  imm_t        r_s1_type;
  logic        r_s2_valid;
  logic [31:0] r_s2_inst;

  logic        w_accept;
  logic        w_s2_adv;
  logic        w_out_fire;
  imm_t        w_in_type;
  logic [31:0] w_enc_inst;

  assign in_ready   = reset_n & r_rdy & (!r_s1_valid | !r_s2_valid | out_ready);
  assign w_accept   = in_valid & in_ready;
  assign w_out_fire = r_s2_valid & out_ready;
  assign w_s2_adv   = r_s1_valid & (!r_s2_valid | out_ready);

  // Codes 4-7 fall back to the I format.
  always_comb begin
    w_in_type = IMM_I;
    case (in_imm_type)
      3'd1:    w_in_type = IMM_S;
      3'd2:    w_in_type = IMM_U;
      3'd3:    w_in_type = IMM_J;
      default: w_in_type = IMM_I;
    endcase
  end

  always_comb begin
    w_enc_inst = r_s1_inst;
    case (r_s1_type)
      IMM_I: w_enc_inst[31:20] = r_s1_imm[11:0];
      IMM_S: begin
        w_enc_inst[31:25] = r_s1_imm[11:5];
        w_enc_inst[11:7]  = r_s1_imm[4:0];
      end
      IMM_U: w_enc_inst[31:12] = r_s1_imm[31:12];
      IMM_J: w_enc_inst[31:12] = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12]};
      default: w_enc_inst = r_s1_inst;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdy      <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_inst  <= 32'h0;
    end else begin
      r_rdy <= 1'b1;
      if (w_accept)
        r_s1_valid <= 1'b1;
      else if (w_s2_adv)
        r_s1_valid <= 1'b0;
      if (w_s2_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_inst  <= w_enc_inst;
      end else if (w_out_fire) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  // Stage-1 payload is only meaningful while r_s1_valid is set.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_inst <= in_inst;
      r_s1_imm  <= in_imm;
      r_s1_type <= w_in_type;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_inst  = r_s2_inst;

`ifdef VSCALE_IMM_ENC_RANGE_CHECK_EN
  logic                 r_s2_err;
  logic [CNT_WIDTH-1:0] r_err_count;
  logic                 w_i_ok;
  logic                 w_u_ok;
  logic                 w_j_ok;
  logic                 w_enc_err;

  assign w_i_ok = (&r_s1_imm[31:11]) | ~(|r_s1_imm[31:11]);
  assign w_u_ok = (r_s1_imm[11:0] == 12'h000);
  assign w_j_ok = ((&r_s1_imm[31:20]) | ~(|r_s1_imm[31:20])) & ~r_s1_imm[0];

  always_comb begin
    w_enc_err = 1'b0;
    case (r_s1_type)
      IMM_I, IMM_S: w_enc_err = ~w_i_ok;
      IMM_U:        w_enc_err = ~w_u_ok;
      IMM_J:        w_enc_err = ~w_j_ok;
      default:      w_enc_err = ~w_i_ok;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s2_err    <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_s2_adv)
        r_s2_err <= w_enc_err;
      if (w_out_fire && r_s2_err && !(&r_err_count))
        r_err_count <= r_err_count + CNT_WIDTH'(1);
    end
  end

  assign out_range_err = r_s2_err;
  assign err_count     = r_err_count;
`else
  assign out_range_err = 1'b0;
  assign err_count     = '0;
`endif

endmodule

// File: tb/tb_vscale_imm_enc.sv
// Directed bench for vscale_imm_enc: encoding vectors, backpressure, saturation, reset.
module tb_vscale_imm_enc;

`ifdef VSCALE_IMM_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_imm;
  logic [2:0]  in_imm_type;
  logic        out_ready;

  logic        in_ready, out_valid, out_range_err;
  logic [31:0] out_inst;
  logic [15:0] err_count;
  logic        c2_in_ready, c2_out_valid, c2_out_range_err;
  logic [31:0] c2_out_inst;
  logic [1:0]  c2_err_count;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  vscale_imm_enc dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_imm(in_imm), .in_imm_type(in_imm_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_range_err(out_range_err), .err_count(err_count)
  );

  vscale_imm_enc #(.CNT_WIDTH(2)) dut_c2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(c2_in_ready),
    .in_inst(in_inst), .in_imm(in_imm), .in_imm_type(in_imm_type),
    .out_valid(c2_out_valid), .out_ready(out_ready), .out_inst(c2_out_inst),
    .out_range_err(c2_out_range_err), .err_count(c2_err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_cnt = 0;
  endtask

  // One transaction with out_ready high; checks latency, fields and counter.
  task automatic run_vec(input string tag, input logic [2:0] ty, input logic [31:0] inst,
                         input logic [31:0] imm, input logic [31:0] exp_inst, input bit exp_err);
    @(negedge clk);
    in_valid = 1'b1; in_imm_type = ty; in_inst = inst; in_imm = imm; out_ready = 1'b1;
    #1 chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out_inst"}, out_inst, exp_inst);
    chk({tag, ".err"}, 32'(out_range_err), 32'(exp_err & RC));
    if (exp_err) exp_cnt++;
    @(negedge clk);
    #1;
    chk({tag, ".err_count"}, 32'(err_count), RC ? 32'(exp_cnt) : 32'd0);
    chk({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int sent, rcv, stalls, stale;
    reset_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_imm = '0; in_imm_type = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_inst", out_inst, 32'h0);
    chk("rst.err", 32'(out_range_err), 32'd0);
    chk("rst.err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 chk("rst.release_ready", 32'(in_ready), 32'd1);

    run_vec("i_neg1",  3'd0, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0);
    run_vec("j_800",   3'd3, 32'h0000_006F, 32'h0000_0800, 32'h0010_006F, 1'b0);
    run_vec("j_801",   3'd3, 32'h0000_006F, 32'h0000_0801, 32'h0010_006F, 1'b1);
    run_vec("u_ok",    3'd2, 32'h0000_0037, 32'h1234_5000, 32'h1234_5037, 1'b0);
    run_vec("u_bad",   3'd2, 32'h0000_0037, 32'h1234_5001, 32'h1234_5037, 1'b1);
    run_vec("i_2048",  3'd0, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b1);
    run_vec("i_max",   3'd5, 32'h0000_0013, 32'h0000_07FF, 32'h7FF0_0013, 1'b0);
    run_vec("i_clr",   3'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h000F_FFFF, 1'b0);
    run_vec("s_m4",    3'd1, 32'h0000_2023, 32'hFFFF_FFFC, 32'hFE00_2E23, 1'b0);
    run_vec("j_min",   3'd3, 32'h0000_006F, 32'hFFF0_0000, 32'h8000_006F, 1'b0);
    run_vec("j_ovf",   3'd3, 32'h0000_006F, 32'h0010_0000, 32'h8000_006F, 1'b1);

    // 8 back-to-back requests, out_ready low during cycles 3..6.
    sent = 0; rcv = 0; stalls = 0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      @(negedge clk);
      out_ready   = !(cyc >= 3 && cyc <= 6);
      in_valid    = (sent < 8);
      in_imm_type = 3'd0;
      in_inst     = 32'h0000_0013;
      in_imm      = 32'(sent);
      #1;
      if (in_valid && !in_ready) stalls++;
      if (out_valid && out_ready) begin
        chk($sformatf("bp.out%0d", rcv), out_inst, (32'(rcv) << 20) | 32'h13);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp.sent", 32'(sent), 32'd8);
    chk("bp.rcvd", 32'(rcv), 32'd8);
    chk("bp.stalled", 32'(stalls > 0), 32'd1);
    #1 chk("bp.no_dup", 32'(out_valid), 32'd0);

    // Saturation on the 2-bit counter instance.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      run_vec($sformatf("sat%0d", k), 3'd2, 32'h0000_0037, 32'h0000_0001, 32'h0000_0037, 1'b1);
      chk($sformatf("sat%0d.c2_count", k), 32'(c2_err_count), RC ? 32'((k > 3) ? 3 : k) : 32'd0);
    end

    // Reset with two out-of-range transactions in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_imm_type = 3'd2; in_inst = 32'h37; in_imm = 32'h1;
    @(negedge clk);
    in_imm = 32'h3;
    @(negedge clk);
    #1 chk("mid.full", 32'(out_valid), 32'd1);
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("mid.in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.err_count", 32'(err_count), 32'd0);
    chk("mid.out_inst", out_inst, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    #1 chk("mid.ready_back", 32'(in_ready), 32'd1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (out_valid || err_count != 16'd0) stale++;
    end
    chk("mid.no_stale", 32'(stale), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
